// File: rtl/ysyx_25020047_lsu_pkg.sv
// Shared definitions for the ysyx_25020047 load/store unit: funct3 codes,
// FSM state encoding and the default memory-acknowledge timeout.
package ysyx_25020047_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int unsigned LSU_TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_e;

    function automatic logic f3_legal(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/ysyx_25020047_lsu_if.sv
// Data-memory request/acknowledge bus between the LSU (master) and memory (slave).
interface ysyx_25020047_lsu_if;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
        output mem_ack, mem_rdata
    );

endinterface

// File: rtl/ysyx_25020047_lsu_align.sv
// Combinational byte-lane logic: store shift/mask and misalign detection on the
// incoming operation, load shift/extend on the latched operation.
module ysyx_25020047_lsu_align
    import ysyx_25020047_pkg::*;
(
    input  logic [2:0]  st_funct3_i,
    input  logic [1:0]  st_off_i,
    input  logic [31:0] st_wdata_i,
    output logic [31:0] st_wdata_o,
    output logic [3:0]  st_wmask_o,
    output logic        misalign_o,
    output logic        f3_illegal_o,

    input  logic [2:0]  ld_funct3_i,
    input  logic [1:0]  ld_off_i,
    input  logic [31:0] ld_rdata_i,
    output logic [31:0] ld_data_o
);

    logic        is_b;
    logic        is_h;
    logic        is_w;
    logic [31:0] rd_shift;

    // Unsigned variants share the access size of their signed counterparts.
    assign is_b = (st_funct3_i[1:0] == 2'b00);
    assign is_h = (st_funct3_i[1:0] == 2'b01);
    assign is_w = (st_funct3_i[1:0] == 2'b10);

    assign st_wdata_o   = st_wdata_i << {st_off_i, 3'b000};
    assign misalign_o   = (is_h & st_off_i[0]) | (is_w & (st_off_i != 2'b00));
    assign f3_illegal_o = ~f3_legal(st_funct3_i);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign st_wmask_o[gi] = is_w
                | ((is_b | is_h) & ({1'b0, st_off_i} == 3'(gi)))
                | (is_h & (({1'b0, st_off_i} + 3'd1) == 3'(gi)));
        end
    endgenerate

    always_comb begin
        rd_shift  = ld_rdata_i >> {ld_off_i, 3'b000};
        ld_data_o = '0;
        case (ld_funct3_i)
            F3_B:    ld_data_o = {{24{rd_shift[7]}}, rd_shift[7:0]};
            F3_H:    ld_data_o = {{16{rd_shift[15]}}, rd_shift[15:0]};
            F3_W:    ld_data_o = rd_shift;
            F3_BU:   ld_data_o = {24'b0, rd_shift[7:0]};
            F3_HU:   ld_data_o = {16'b0, rd_shift[15:0]};
            default: ld_data_o = '0;
        endcase
    end

endmodule

// File: rtl/ysyx_25020047_lsu.sv
// Load/store unit: one memory operation at a time from execute, req/ack on the
// data-memory bus, aligned load data handed to write-back via valid/ready.
module ysyx_25020047_lsu
    import ysyx_25020047_pkg::*;
#(
    parameter int unsigned TIMEOUT = LSU_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic        ren_i,
    input  logic        wen_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,

    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] memdata_o,
    output logic        err_o,

    ysyx_25020047_lsu_if.master mem
);

    localparam int unsigned        CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_e state_q, state_d;

    logic             mem_req_q;
    logic             mem_we_q;
    logic [31:0]      mem_addr_q;
    logic [31:0]      mem_wdata_q;
    logic [3:0]       mem_wmask_q;
    logic [31:0]      memdata_q;
    logic             err_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       ld_f3_q;
    logic [1:0]       ld_off_q;

    logic [31:0] lane_wdata;
    logic [3:0]  lane_wmask;
    logic        lane_misalign;
    logic        lane_illegal;
    logic [31:0] lane_ldata;

    logic accept;
    logic go_req;
    logic timeout_hit;

    ysyx_25020047_lsu_align u_align (
        .st_funct3_i  (funct3_i),
        .st_off_i     (addr_i[1:0]),
        .st_wdata_i   (wdata_i),
        .st_wdata_o   (lane_wdata),
        .st_wmask_o   (lane_wmask),
        .misalign_o   (lane_misalign),
        .f3_illegal_o (lane_illegal),
        .ld_funct3_i  (ld_f3_q),
        .ld_off_i     (ld_off_q),
        .ld_rdata_i   (mem.mem_rdata),
        .ld_data_o    (lane_ldata)
    );

    assign accept      = in_valid_i && (state_q == ST_IDLE);
    assign go_req      = (ren_i ^ wen_i) && !lane_illegal && !lane_misalign;
    // Counter holds the number of REQ cycles already spent without ack, so the
    // request is abandoned after exactly TIMEOUT cycles on the bus.
    assign timeout_hit = (cnt_q == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = go_req ? ST_REQ : ST_RESP;
                end
            end
            ST_REQ: begin
                if (mem.mem_ack || timeout_hit) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (out_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready_o  = (state_q == ST_IDLE);
        out_valid_o = (state_q == ST_RESP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wmask_q <= '0;
            memdata_q   <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            ld_f3_q     <= '0;
            ld_off_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        ld_f3_q   <= funct3_i;
                        ld_off_q  <= addr_i[1:0];
                        memdata_q <= '0;
                        if (go_req) begin
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= wen_i;
                            mem_addr_q  <= {addr_i[31:2], 2'b00};
                            mem_wdata_q <= wen_i ? lane_wdata : '0;
                            mem_wmask_q <= wen_i ? lane_wmask : '0;
                            cnt_q       <= '0;
                            err_q       <= 1'b0;
                        end else begin
                            // Any memory-flavoured op that cannot be issued is an error;
                            // a plain non-memory op is not.
                            err_q <= ren_i | wen_i;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem.mem_ack) begin
                        mem_req_q <= 1'b0;
                        memdata_q <= mem_we_q ? '0 : lane_ldata;
                        err_q     <= 1'b0;
                    end else if (timeout_hit) begin
                        mem_req_q <= 1'b0;
                        memdata_q <= '0;
                        err_q     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign mem.mem_wmask = mem_wmask_q;
    assign memdata_o     = memdata_q;
    assign err_o         = err_q;

endmodule
